// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS symbol constants and receiver state encoding, shared with the encoder
package tmds_pkg;
   localparam int SYM_W        = 10;
   localparam int BITS_PER_CLK = 2;
   localparam logic [SYM_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
   localparam logic [SYM_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
   localparam logic [SYM_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
   localparam logic [SYM_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;
   typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} lane_state_e;
endpackage

// File: rtl/tmds_symbol_decode.sv
// tmds_symbol_decode: combinational 10b TMDS symbol to {de, ctrl, data}
module tmds_symbol_decode
   import tmds_pkg::*;
(
   input  logic [SYM_W-1:0] sym_i,
   output logic             de_o,
   output logic [1:0]       ctrl_o,
   output logic [7:0]       data_o
);
   logic [7:0] d;
   logic [7:0] raw;
   always_comb begin
      d = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
      raw = '0;
      raw[0] = d[0];
      for (int i = 1; i < 8; i++) raw[i] = sym_i[8] ? d[i] ^ d[i-1] : ~(d[i] ^ d[i-1]);
      de_o = !(sym_i inside {CTRL_TOKEN_00, CTRL_TOKEN_01, CTRL_TOKEN_10, CTRL_TOKEN_11});
      ctrl_o = (sym_i == CTRL_TOKEN_01) ? 2'b01 :
               (sym_i == CTRL_TOKEN_10) ? 2'b10 :
               (sym_i == CTRL_TOKEN_11) ? 2'b11 : 2'b00;
      data_o = de_o ? raw : 8'h00;
   end
endmodule

// File: rtl/tmds_rx_lane.sv
// tmds_rx_lane: one TMDS lane - 2:10 deserializer, token-driven bit alignment, registered decode
module tmds_rx_lane
   import tmds_pkg::*;
#(
   parameter int LOCK_TOKENS = 8,
   parameter int SLIP_WORDS  = 1024,
   parameter int LOSS_WORDS  = 4096
) (
   input  logic       tmds_clk_i,
   input  logic       reset_i,
   input  logic [1:0] in_tmds_i,
   output logic       out_word_valid_o,
   output logic       out_de_o,
   output logic [7:0] out_data_o,
   output logic [1:0] out_ctrl_o,
   output logic       out_locked_o,
   output logic [3:0] out_bit_offset_o
);
   localparam int TW   = $clog2(LOCK_TOKENS) + 1;
   localparam int MW   = $clog2(SLIP_WORDS) + 1;
   localparam int LW   = $clog2(LOSS_WORDS) + 1;
   localparam int SR_W = 2 * SYM_W;
   localparam logic [2:0]    PH_LAST   = 3'(SYM_W / BITS_PER_CLK - 1);
   localparam logic [3:0]    OFF_LAST  = 4'(SYM_W - 1);
   localparam logic [TW-1:0] TOK_LAST  = TW'(LOCK_TOKENS - 1);
   localparam logic [MW-1:0] MISS_LAST = MW'(SLIP_WORDS - 1);
   localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_WORDS - 1);

   logic [SR_W-1:0]  sreg_q, sreg_d;
   logic [2:0]       phase_q;
   logic [3:0]       off_q;
   lane_state_e      state_q;
   logic [TW-1:0]    tok_q;
   logic [MW-1:0]    miss_q;
   logic [LW-1:0]    loss_q;
   logic             valid_q, de_q, locked_q;
   logic [7:0]       data_q;
   logic [1:0]       ctrl_q;
   logic [SYM_W-1:0] sym;
   logic             dec_de;
   logic [1:0]       dec_ctrl;
   logic [7:0]       dec_data;

   // oldest bit sits at the LSB; symbol is taken from the register's incoming value
   assign sreg_d = {in_tmds_i, sreg_q[SR_W-1:BITS_PER_CLK]};
   assign sym    = SYM_W'(sreg_d >> off_q);

   tmds_symbol_decode u_dec (
      .sym_i  (sym),
      .de_o   (dec_de),
      .ctrl_o (dec_ctrl),
      .data_o (dec_data)
   );

   always_ff @(posedge tmds_clk_i) begin
      if (reset_i) begin
         sreg_q   <= '0;
         phase_q  <= '0;
         off_q    <= '0;
         state_q  <= SEARCH;
         tok_q    <= '0;
         miss_q   <= '0;
         loss_q   <= '0;
         valid_q  <= 1'b0;
         de_q     <= 1'b0;
         data_q   <= '0;
         ctrl_q   <= '0;
         locked_q <= 1'b0;
      end else begin
         sreg_q  <= sreg_d;
         phase_q <= (phase_q == PH_LAST) ? 3'd0 : phase_q + 3'd1;
         valid_q <= (phase_q == PH_LAST);
         if (phase_q == PH_LAST) begin
            de_q   <= dec_de;
            data_q <= dec_data;
            if (!dec_de) ctrl_q <= dec_ctrl;
            case (state_q)
               SEARCH: begin
                  if (!dec_de) begin
                     miss_q <= '0;
                     tok_q  <= tok_q + 1'b1;
                     if (tok_q == TOK_LAST) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                        tok_q    <= '0;
                        loss_q   <= '0;
                     end
                  end else begin
                     tok_q  <= '0;
                     miss_q <= miss_q + 1'b1;
                     if (miss_q == MISS_LAST) begin
                        off_q  <= (off_q == OFF_LAST) ? 4'd0 : off_q + 4'd1;
                        miss_q <= '0;
                     end
                  end
               end
               LOCKED: begin
                  loss_q <= dec_de ? loss_q + 1'b1 : '0;
                  if (dec_de && loss_q == LOSS_LAST) begin
                     state_q  <= SEARCH;
                     locked_q <= 1'b0;
                     loss_q   <= '0;
                     tok_q    <= '0;
                     miss_q   <= '0;
                  end
               end
               default: state_q <= SEARCH;
            endcase
         end
      end
   end

   assign out_word_valid_o = valid_q;
   assign out_de_o         = de_q;
   assign out_data_o       = data_q;
   assign out_ctrl_o       = ctrl_q;
   assign out_locked_o     = locked_q;
   assign out_bit_offset_o = off_q;
endmodule

// File: tb/tb_tmds_rx_lane.sv
// tb_tmds_rx_lane: scoreboard bench for tmds_rx_lane (LOCK_TOKENS=8, SLIP_WORDS=4, LOSS_WORDS=32)
module tb_tmds_rx_lane;
   localparam logic [1:0] K_DC = 2'd0, K_TOK = 2'd1, K_DAT = 2'd2;
   localparam logic [9:0] T00 = 10'b1101010100;

   typedef struct {
      logic [1:0] kind;
      logic [1:0] ctrl;
      logic [7:0] data;
      logic       chk_st;
      logic       locked;
      logic [3:0] off;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] in_tmds = 2'b00;
   logic       out_word_valid, out_de, out_locked;
   logic [7:0] out_data;
   logic [1:0] out_ctrl;
   logic [3:0] out_bit_offset;

   exp_t  exq[$];
   logic  bq[$];
   int    n_chk = 0, n_pass = 0;
   int    cyc = 0, last_cyc = -1, n_strobe = 0;
   bit    mon_en = 1'b0;
   int    enc_cnt = 0;
   logic [1:0] last_ctrl = 2'b00;
   string tname = "reset";

   tmds_rx_lane #(.LOCK_TOKENS(8), .SLIP_WORDS(4), .LOSS_WORDS(32)) dut (
      .tmds_clk_i       (clk),
      .reset_i          (rst),
      .in_tmds_i        (in_tmds),
      .out_word_valid_o (out_word_valid),
      .out_de_o         (out_de),
      .out_data_o       (out_data),
      .out_ctrl_o       (out_ctrl),
      .out_locked_o     (out_locked),
      .out_bit_offset_o (out_bit_offset)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [9:0] tok(input int c);
      return c == 0 ? 10'b1101010100 : c == 1 ? 10'b0010101011 :
             c == 2 ? 10'b0101010100 : 10'b1010101011;
   endfunction

   // reference DVI encoder with running disparity
   function automatic logic [9:0] tmds_enc(input logic [7:0] d);
      logic [8:0] qm;
      logic       use_xnor;
      int         n1q;
      logic [9:0] q;
      use_xnor = ($countones(d) > 4) || ($countones(d) == 4 && !d[0]);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : qm[i-1] ^ d[i];
      qm[8] = !use_xnor;
      n1q = $countones(qm[7:0]);
      if (enc_cnt == 0 || n1q == 4) begin
         q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         enc_cnt += qm[8] ? (2 * n1q - 8) : (8 - 2 * n1q);
      end else if ((enc_cnt > 0 && n1q > 4) || (enc_cnt < 0 && n1q < 4)) begin
         q = {1'b1, qm[8], ~qm[7:0]};
         enc_cnt += (qm[8] ? 2 : 0) + 8 - 2 * n1q;
      end else begin
         q = {1'b0, qm[8], qm[7:0]};
         enc_cnt += (qm[8] ? 0 : -2) + 2 * n1q - 8;
      end
      return q;
   endfunction

   task automatic add_exp(input logic [1:0] kind, input logic [1:0] ctrl, input logic [7:0] data,
                          input logic chk_st, input logic lk, input logic [3:0] off);
      exp_t e;
      e.kind = kind; e.ctrl = ctrl; e.data = data; e.chk_st = chk_st; e.locked = lk; e.off = off;
      exq.push_back(e);
   endtask

   task automatic push_raw(input logic [9:0] s);
      for (int i = 0; i < 10; i++) bq.push_back(s[i]);
   endtask

   task automatic push_sym(input logic [9:0] s, input logic [1:0] kind, input logic [1:0] ctrl,
                           input logic [7:0] data, input logic lk, input logic [3:0] off);
      push_raw(s);
      add_exp(kind, ctrl, data, 1'b1, lk, off);
   endtask

   task automatic push_tok(input int c, input logic lk, input logic [3:0] off, input bit dc);
      enc_cnt = 0;
      last_ctrl = 2'(c);
      push_sym(tok(c), dc ? K_DC : K_TOK, 2'(c), 8'h00, lk, off);
   endtask

   task automatic push_dat(input logic [7:0] b, input logic lk, input logic [3:0] off);
      push_sym(tmds_enc(b), K_DAT, last_ctrl, b, lk, off);
   endtask

   // zero-filled history strobe right after reset: all-zero symbol decodes as data 0xFE
   task automatic add_hist();
      add_exp(K_DAT, 2'b00, 8'hFE, 1'b1, 1'b0, 4'd0);
   endtask

   task automatic do_reset(input string name);
      mon_en = 1'b0; rst = 1'b1; in_tmds = 2'b00;
      bq.delete(); exq.delete();
      enc_cnt = 0; last_ctrl = 2'b00; tname = name;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      mon_en = 1'b1; last_cyc = -1; n_strobe = 0;
   endtask

   task automatic play(input int ncyc);
      for (int k = 0; k < ncyc; k++) begin
         logic b0, b1;
         b0 = (bq.size() > 0) ? bq.pop_front() : 1'b0;
         b1 = (bq.size() > 0) ? bq.pop_front() : 1'b0;
         in_tmds = {b1, b0};
         @(posedge clk); #1;
      end
   endtask

   task automatic drain();
      @(negedge clk); #1;
      check({tname, "_pending"}, exq.size(), 0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, out_word_valid, 0);
      check({tag, "_de"}, out_de, 0);
      check({tag, "_data"}, out_data, 0);
      check({tag, "_ctrl"}, out_ctrl, 0);
      check({tag, "_locked"}, out_locked, 0);
      check({tag, "_offset"}, out_bit_offset, 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (mon_en && !rst && out_word_valid) begin
         n_strobe++;
         if (last_cyc >= 0) check($sformatf("%s_gap@%0d", tname, n_strobe), cyc - last_cyc, 5);
         last_cyc = cyc;
         if (exq.size() == 0) check($sformatf("%s_extra@%0d", tname, n_strobe), 1, 0);
         else begin
            e = exq.pop_front();
            if (e.kind != K_DC) begin
               check($sformatf("%s_de@%0d", tname, n_strobe), out_de, e.kind == K_DAT);
               check($sformatf("%s_ctrl@%0d", tname, n_strobe), out_ctrl, e.ctrl);
               check($sformatf("%s_data@%0d", tname, n_strobe), out_data, e.data);
            end
            if (e.chk_st) begin
               check($sformatf("%s_locked@%0d", tname, n_strobe), out_locked, e.locked);
               check($sformatf("%s_offset@%0d", tname, n_strobe), out_bit_offset, e.off);
            end
         end
      end
   end

   initial begin
      int k;
      repeat (3) @(posedge clk);
      #1 check_zero("reset");

      // idle zeros: slip every 4 strobes, 9 -> 0 wrap at strobe 40
      do_reset("idle");
      add_hist();
      for (int n = 2; n <= 41; n++) push_sym(10'd0, K_DAT, 2'b00, 8'hFE, 1'b0, 4'((n / 4) % 10));
      push_raw(10'd0);
      play((bq.size() + 1) / 2);
      drain();

      // aligned token run: lock on the 8th token
      do_reset("lock");
      add_hist();
      for (int i = 0; i < 8; i++) push_tok(0, i == 7, 4'd0, 1'b0);
      push_raw(T00);
      play((bq.size() + 1) / 2);
      drain();

      // every control token, ctrl hold across data, both 0x10 encodings
      do_reset("ctrl");
      add_hist();
      for (int c = 0; c < 4; c++) push_tok(c, 1'b0, 4'd0, 1'b0);
      push_sym(10'b0111110000, K_DAT, 2'b11, 8'h10, 1'b0, 4'd0);
      push_sym(10'b1100001111, K_DAT, 2'b11, 8'h10, 1'b0, 4'd0);
      push_tok(1, 1'b0, 4'd0, 1'b0);
      push_dat(8'h55, 1'b0, 4'd0);
      push_dat(8'hA3, 1'b0, 4'd0);
      push_raw(T00);
      play((bq.size() + 1) / 2);
      drain();

      // stream delayed 3 bits: slips at strobes 4/8/12, lock at strobe 20, then loss of lock
      do_reset("align");
      repeat (3) bq.push_back(1'b0);
      add_hist();
      for (int i = 0; i < 24; i++)
         push_tok(0, i + 2 >= 20, (i + 2 >= 12) ? 4'd3 : (i + 2 >= 8) ? 4'd2 : (i + 2 >= 4) ? 4'd1 : 4'd0, i <= 10);
      for (int r = 0; r < 2; r++) begin
         push_dat(8'h00, 1'b1, 4'd3);
         push_dat(8'h55, 1'b1, 4'd3);
         push_dat(8'hFF, 1'b1, 4'd3);
         push_dat(8'hA3, 1'b1, 4'd3);
         for (int i = 0; i < 10; i++) push_tok(0, 1'b1, 4'd3, 1'b0);
      end
      for (int i = 0; i < 30; i++) push_dat(8'(i * 37 + 5), 1'b1, 4'd3);
      push_tok(0, 1'b1, 4'd3, 1'b0);
      for (int i = 0; i < 32; i++) push_dat(8'(i * 53 + 1), i != 31, 4'd3);
      push_raw(T00);
      play((bq.size() + 1) / 2);
      drain();

      // reset pulse mid-symbol while locked
      do_reset("midrst");
      add_hist();
      for (int i = 0; i < 9; i++) push_tok(0, i >= 7, 4'd0, 1'b0);
      push_raw(T00);
      push_raw(T00);
      play(50);
      drain();
      play(2);
      check("midrst_pre_locked", out_locked, 1);
      mon_en = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      check_zero("midrst");
      rst = 1'b0;
      in_tmds = 2'b00;
      bq.delete();
      k = 0;
      while (k < 20 && !out_word_valid) begin
         @(posedge clk); #1;
         k++;
      end
      check("midrst_first_strobe", k, 5);
      check("midrst_first_locked", out_locked, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
